// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard controller: forwarding, stall/flush, multiply sequencing, stall counter
module hazard_controller #(
    parameter int REG_BITS    = 4,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  Ra1D,
    input  logic [REG_BITS-1:0]  Ra2D,
    input  logic [REG_BITS-1:0]  Ra1E,
    input  logic [REG_BITS-1:0]  Ra2E,
    input  logic [REG_BITS-1:0]  WA3E,
    input  logic [REG_BITS-1:0]  WA3M,
    input  logic [REG_BITS-1:0]  WA3W,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemToRegE,
    input  logic                 PCSrcD,
    input  logic                 PCSrcE,
    input  logic                 PCSrcM,
    input  logic                 PCSrcW,
    input  logic                 BranchTakenE,
    input  logic                 MulE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 MulBusy,
    output logic [CNT_WIDTH-1:0] StallCount
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // A single-cycle multiply needs no sequencing, so the FSM stays in RUN.
    localparam bit         MUL_SEQ  = (MUL_LATENCY >= 2);
    localparam logic [3:0] MUL_INIT = MUL_SEQ ? 4'(MUL_LATENCY - 2) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic       mul_stall;
    logic       ldr_stall;
    logic       pc_wr_pend;

    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] ra);
        if (RegWriteM && (ra == WA3M))
            return 2'b10;
        else if (RegWriteW && (ra == WA3W))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ldr_stall  = MemToRegE && RegWriteE && ((Ra1D == WA3E) || (Ra2D == WA3E));
        pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;
    end

    always_comb begin
        mul_stall = 1'b0;
        case (state)
            RUN:      mul_stall = MUL_SEQ && MulE;
            MUL_BUSY: mul_stall = (cnt != 4'd0);
            default:  mul_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (MUL_SEQ && MulE) begin
                        state <= MUL_BUSY;
                        cnt   <= MUL_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (cnt == 4'd0)
                        state <= RUN;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // While the multiply is stalling, Execute holds via its enable, so only M gets a bubble.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
        MulBusy   = 1'b0;
        if (reset) begin
            ForwardAE = fwd_sel(Ra1E);
            ForwardBE = fwd_sel(Ra2E);
            MulBusy   = (state == MUL_BUSY);
            if (mul_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushM = 1'b1;
            end else begin
                StallF = ldr_stall || pc_wr_pend;
                StallD = ldr_stall;
                FlushD = pc_wr_pend || PCSrcW || BranchTakenE;
                FlushE = ldr_stall || BranchTakenE;
                FlushM = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            StallCount <= '0;
        else if (StallF && (StallCount != '1))
            StallCount <= StallCount + 1'b1;
    end

endmodule
